reconf_fir_core: RTL

Parametrised reconfigurable FIR engine, the successor to the fixed four-bank filter top.

- Implements `NUM_BANK` parallel MAC lanes. Each lane has its own `TAPS`-deep coefficient store and walks its taps one per clock after each sample strobe.
- Adds run-time filter length (active bank count), a valid/ready coefficient-load handshake, output saturation and dropped-sample reporting.
- Sits between the sample-rate enable generator and the output formatter in the 12 MHz domain.

---
 rtl/reconf_fir_core.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/reconf_fir_core.sv
// Reconfigurable multi-lane FIR engine: per-lane coefficient banks, run-time
// bank count, valid/ready coefficient loading, output saturation.
module reconf_fir_core #(
    parameter int NUM_BANK = 4,
    parameter int TAPS     = 10,
    parameter int DATA_W   = 3,
    parameter int COEF_W   = 16,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 0
) (
    input  logic                              iClk12M,
    input  logic                              iRsn,
    input  logic                              iEnSample,
    input  logic signed [DATA_W-1:0]          iFirIn,
    input  logic [$clog2(NUM_BANK+1)-1:0]     iBankCnt,
    input  logic                              iCoeffUpdate,
    input  logic                              iCoeffValid,
    input  logic signed [COEF_W-1:0]          iCoeffData,
    output logic                              oCoeffReady,
    output logic signed [OUT_W-1:0]           oFirOut,
    output logic                              oFirValid,
    output logic                              oBusy,
    output logic                              oSampleDrop
);

    localparam int L      = NUM_BANK * TAPS;
    localparam int BCW    = $clog2(NUM_BANK + 1);
    localparam int KW     = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int TCW    = $clog2(TAPS + 1);
    localparam int WCW    = (L > 1) ? $clog2(L) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SUM_W  = ACC_W + $clog2(NUM_BANK);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] MAC  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic signed [SUM_W-1:0] OMAX =
        {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OMIN =
        {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [1:0]                state;
    logic signed [DATA_W-1:0]  xLine  [L];
    logic signed [COEF_W-1:0]  coef   [L];
    logic signed [COEF_W-1:0]  coefRd [NUM_BANK];
    logic signed [ACC_W-1:0]   acc    [NUM_BANK];
    logic signed [PROD_W-1:0]  prodV  [NUM_BANK];
    logic signed [ACC_W-1:0]   laneAdd[NUM_BANK];
    logic [TCW-1:0]            tapCnt;
    logic [KW-1:0]             tapRd;
    logic                      rdVld;
    logic [WCW-1:0]            wrCnt;
    logic [BCW-1:0]            bankSel;
    logic signed [SUM_W-1:0]   sumAll;
    logic signed [SUM_W-1:0]   shifted;
    logic signed [OUT_W-1:0]   satOut;
    logic                      coefXfer;
    logic                      strobeOk;

    assign oCoeffReady = (state == LOAD);
    assign oBusy       = (state != IDLE);
    assign coefXfer    = (state == LOAD) && iCoeffValid;
    assign strobeOk    = (state == IDLE) && !iCoeffUpdate && iEnSample;

    // Delay line is frozen during MAC, so it can be read in the accumulate cycle
    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            prodV[b]   = xLine[WCW'(b*TAPS) + WCW'(tapRd)] * coefRd[b];
            laneAdd[b] = (b < int'(bankSel)) ? ACC_W'(prodV[b]) : '0;
        end
    end

    always_comb begin
        sumAll = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            sumAll = sumAll + SUM_W'(acc[b]);
        end
        shifted = sumAll >>> SHIFT;
        if (shifted > OMAX) begin
            satOut = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted < OMIN) begin
            satOut = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            satOut = shifted[OUT_W-1:0];
        end
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state       <= IDLE;
            tapCnt      <= '0;
            tapRd       <= '0;
            rdVld       <= 1'b0;
            wrCnt       <= '0;
            bankSel     <= '0;
            oFirOut     <= '0;
            oFirValid   <= 1'b0;
            oSampleDrop <= 1'b0;
            for (int i = 0; i < L; i++) begin
                xLine[i] <= '0;
                coef[i]  <= '0;
            end
            for (int b = 0; b < NUM_BANK; b++) begin
                coefRd[b] <= '0;
                acc[b]    <= '0;
            end
        end else begin
            oFirValid   <= 1'b0;
            oSampleDrop <= iEnSample && !strobeOk;
            if (coefXfer) begin
                coef[wrCnt] <= iCoeffData;
            end
            unique case (state)
                IDLE: begin
                    if (iCoeffUpdate) begin
                        state <= LOAD;
                        wrCnt <= '0;
                    end else if (iEnSample) begin
                        xLine[0] <= iFirIn;
                        for (int i = 1; i < L; i++) begin
                            xLine[i] <= xLine[i-1];
                        end
                        bankSel <= (iBankCnt > BCW'(NUM_BANK))
                                 ? BCW'(NUM_BANK) : iBankCnt;
                        for (int b = 0; b < NUM_BANK; b++) begin
                            acc[b] <= '0;
                        end
                        tapCnt <= '0;
                        rdVld  <= 1'b0;
                        state  <= MAC;
                    end
                end
                LOAD: begin
                    if (coefXfer) begin
                        if (wrCnt == WCW'(L-1)) begin
                            wrCnt <= '0;
                            state <= IDLE;
                        end else begin
                            wrCnt <= wrCnt + 1'b1;
                        end
                    end
                    if (!iCoeffUpdate) begin
                        wrCnt <= '0;
                        state <= IDLE;
                    end
                end
                MAC: begin
                    if (tapCnt != TCW'(TAPS)) begin
                        for (int b = 0; b < NUM_BANK; b++) begin
                            coefRd[b] <= coef[WCW'(b*TAPS) + WCW'(tapCnt)];
                        end
                        tapRd  <= KW'(tapCnt);
                        tapCnt <= tapCnt + 1'b1;
                        rdVld  <= 1'b1;
                    end else begin
                        rdVld <= 1'b0;
                    end
                    if (rdVld) begin
                        for (int b = 0; b < NUM_BANK; b++) begin
                            acc[b] <= acc[b] + laneAdd[b];
                        end
                        if (tapRd == KW'(TAPS-1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    oFirOut   <= satOut;
                    oFirValid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
